// File: rtl/fp_convert_ctrl.sv
// ============================================================================
//  Module      : fp_convert_ctrl
//  Description : Sequencing controller for 12-bit two's-complement linear to
//                8-bit {sign, exp[2:0], sig[3:0]} floating-point conversion.
//                Optional saturation counter enabled by FPCVT_SAT_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_convert_ctrl #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef FPCVT_SAT_CNT_EN
    ,
    output logic [7:0]       sat_count
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ABS  = 3'd1;
    localparam logic [2:0] S_NORM = 3'd2;
    localparam logic [2:0] S_RND  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  r_state;
    logic [11:0] r_in;
    logic        r_sign;
    logic [11:0] r_mag;
    logic [2:0]  r_exp;
    logic [3:0]  r_sig;
    logic        r_rb;

    logic [11:0] w_mag_abs;
    logic [2:0]  w_exp;
    logic [3:0]  w_idx;
    logic [3:0]  w_sig;
    logic        w_rb;
    logic [4:0]  w_sum;
    logic [2:0]  w_rnd_exp;
    logic [3:0]  w_rnd_sig;
    logic        w_sat;

    // -2048 has no positive twin in 12 bits, so it is clamped to 2047.
    always_comb begin
        w_mag_abs = r_in;
        if (r_in == 12'h800) begin
            w_mag_abs = 12'h7FF;
        end else if (r_in[11]) begin
            w_mag_abs = (~r_in) + 12'd1;
        end
    end

    // Exponent is the position of the leading one minus 3, floored at 0.
    always_comb begin
        w_exp = 3'd0;
        for (int i = 4; i < 12; i++) begin
            if (r_mag[i]) begin
                w_exp = 3'(i - 3);
            end
        end
        w_idx = {1'b0, w_exp};
        w_sig = r_mag[w_idx +: 4];
        w_rb  = (w_exp == 3'd0) ? 1'b0 : r_mag[w_idx - 4'd1];
    end

    always_comb begin
        w_sum     = {1'b0, r_sig} + {4'd0, r_rb};
        w_rnd_exp = r_exp;
        w_rnd_sig = w_sum[3:0];
        w_sat     = 1'b0;
        if (w_sum[4]) begin
            if (r_exp == 3'd7) begin
                w_rnd_sig = 4'hF;
                w_sat     = 1'b1;
            end else begin
                w_rnd_exp = r_exp + 3'd1;
                w_rnd_sig = 4'h8;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_in      <= 12'd0;
            r_sign    <= 1'b0;
            r_mag     <= 12'd0;
            r_exp     <= 3'd0;
            r_sig     <= 4'd0;
            r_rb      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_in     <= in_data;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_ABS;
                    end
                end
                S_ABS: begin
                    r_sign  <= r_in[11];
                    r_mag   <= w_mag_abs;
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_exp   <= w_exp;
                    r_sig   <= w_sig;
                    r_rb    <= w_rb;
                    r_state <= S_RND;
                end
                S_RND: begin
                    out_data  <= {r_sign, w_rnd_exp, w_rnd_sig};
                    out_valid <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FPCVT_SAT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= 8'd0;
        end else if ((r_state == S_RND) && w_sat && (sat_count != 8'hFF)) begin
            sat_count <= sat_count + 8'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_convert_ctrl.sv
// ============================================================================
//  Module      : tb_fp_convert_ctrl
//  Description : Self-checking bench for fp_convert_ctrl (vector table,
//                handwritten corner sequences, randomized model comparison).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_convert_ctrl;

    logic        clk;
    logic        rst;
    logic [11:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
`ifdef FPCVT_SAT_CNT_EN
    logic [7:0]  sat_count;
`endif

    int checks   = 0;
    int failures = 0;
    int sat_model = 0;

    fp_convert_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef FPCVT_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [11:0] din;
        logic [7:0]  dout;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Rounded value = floor(mag / 2^e + 1/2), with mag in [8*2^e, 16*2^e).
    function automatic logic [8:0] model(input logic [11:0] d);
        int v, s, m, e, r, sat;
        v = int'($signed(d));
        s = (v < 0) ? 1 : 0;
        m = (v < 0) ? -v : v;
        if (m > 2047) m = 2047;
        if (m < 16) return {1'b0, s[0], 3'd0, m[3:0]};
        e = 0;
        while (m >= (16 << e)) e++;
        r = (m + (1 << (e - 1))) >> e;
        if (r == 16) begin
            r = 8;
            e++;
        end
        sat = 0;
        if (e > 7) begin
            e = 7;
            r = 15;
            sat = 1;
        end
        return {sat[0], s[0], e[2:0], r[3:0]};
    endfunction

    // Called at a negedge; returns at the negedge after the output handshake.
    task automatic do_conv(input logic [11:0] d, input int stall,
                           output logic [7:0] res, output int lat);
        int g;
        logic [8:0] mm;
        g = 0;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_data;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_hold{valid,in_ready,data}", {22'd0, out_valid, in_ready, out_data},
                {22'd0, 1'b1, 1'b0, res});
        end
        out_ready = 1'b1;
        @(negedge clk);
        mm = model(d);
        if (mm[8]) sat_model++;
    endtask

    initial begin
        logic [7:0]  res;
        logic [8:0]  mm;
        logic [11:0] d;
        int          lat;
        int          seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 12'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", {24'd0, out_data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
`ifdef FPCVT_SAT_CNT_EN
        chk("reset_sat_count", {24'd0, sat_count}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        vecs[0]  = '{12'h000, 8'h00};
        vecs[1]  = '{12'h1A6, 8'h5D};
        vecs[2]  = '{12'hE5A, 8'hDD};
        vecs[3]  = '{12'd46,  8'h2C};
        vecs[4]  = '{12'd63,  8'h38};
        vecs[5]  = '{12'h800, 8'hFF};
        vecs[6]  = '{12'h7FF, 8'h7F};
        vecs[7]  = '{12'd15,  8'h0F};
        vecs[8]  = '{12'd16,  8'h18};
        vecs[9]  = '{12'd17,  8'h19};
        vecs[10] = '{12'hFFF, 8'h81};
        vecs[11] = '{12'd31,  8'h28};
        vecs[12] = '{12'd1024, 8'h78};
        vecs[13] = '{12'd1088, 8'h79};

        for (int i = 0; i < 14; i++) begin
            do_conv(vecs[i].din, 0, res, lat);
            chk($sformatf("vec%0d_data(in=%03h)", i, vecs[i].din), {24'd0, res}, {24'd0, vecs[i].dout});
            chk($sformatf("vec%0d_latency", i), lat, 32'd4);
        end
`ifdef FPCVT_SAT_CNT_EN
        chk("sat_count_after_table", {24'd0, sat_count}, 32'd2);
`endif

        // Back-pressure: ten stalled cycles, then a new accept one cycle after release.
        do_conv(12'h1A6, 10, res, lat);
        chk("bp_data", {24'd0, res}, 32'h5D);
        chk("bp_post_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_post_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_post_data_hold", {24'd0, out_data}, 32'h5D);
        in_data  = 12'd46;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_accept_busy", {31'd0, busy}, 32'd1);
        chk("bp_next_accept_in_ready", {31'd0, in_ready}, 32'd0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_next_latency", lat, 32'd4);
        chk("bp_next_data", {24'd0, out_data}, 32'h2C);
        @(negedge clk);

        // Reset while the sample sits in NORM.
        in_data  = 12'h1A6;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sat_model = 0;
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
`ifdef FPCVT_SAT_CNT_EN
        chk("rst_mid_sat_count", {24'd0, sat_count}, 32'd0);
`endif
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_mid_no_output", seen, 32'd0);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0:       d = 12'h800;
                1:       d = 12'h7FF - 12'($urandom_range(0, 70));
                2:       d = 12'($urandom_range(0, 40));
                default: d = 12'($urandom);
            endcase
            mm = model(d);
            do_conv(d, $urandom_range(0, 3), res, lat);
            chk($sformatf("rand%0d_data(in=%03h)", n, d), {24'd0, res}, {24'd0, mm[7:0]});
            chk($sformatf("rand%0d_latency", n), lat, 32'd4);
        end
`ifdef FPCVT_SAT_CNT_EN
        chk("sat_count_final", {24'd0, sat_count}, (sat_model > 255) ? 32'd255 : sat_model);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
